// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state numbers,
// ALU opcodes, memory direction and the packed control word.
package cpu_ctrl_pkg;

    localparam int STATE_BITS = 7;

    typedef enum logic [STATE_BITS-1:0] {
        S_RESET      = 7'd0,
        S_FETCH_ADDR = 7'd1,
        S_FETCH_WAIT = 7'd2,
        S_IR_LOAD    = 7'd3,
        S_DECODE     = 7'd4,
        S_ADDU       = 7'd6,
        S_ST_ADDR    = 7'd7,
        S_ST_DATA    = 7'd8,
        S_ST_WAIT    = 7'd9,
        S_BEQ        = 7'd11,
        S_BR_TAKE    = 7'd12,
        S_LD_ADDR    = 7'd13,
        S_LD_WAIT    = 7'd14,
        S_LD_WB      = 7'd15,
        S_ERROR      = 7'd16,
        S_SUBU       = 7'd17,
        S_ADDIU      = 7'd18,
        S_SLTU       = 7'd19,
        S_SLTIU      = 7'd20,
        S_CLO        = 7'd21,
        S_CLZ        = 7'd22,
        S_AND        = 7'd23
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLTU = 4'd2;
    localparam logic [3:0] ALU_CLO  = 4'd3;
    localparam logic [3:0] ALU_CLZ  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_sel;
        logic       mar_ld;
        logic       mdr_ld;
        logic       ir_ld;
        logic       rf_ld;
        logic       rf_src;
        logic       mem_en;
        logic       mem_rw;
        logic [3:0] alu_op;
        logic       mem_err;
    } ctrl_word_t;

    // True for the execute states the encoder is allowed to dispatch to.
    function automatic logic is_dispatch_legal(input logic [STATE_BITS-1:0] sel);
        case (sel)
            7'd6, 7'd7, 7'd11, 7'd13,
            7'd17, 7'd18, 7'd19, 7'd20,
            7'd21, 7'd22, 7'd23: is_dispatch_legal = 1'b1;
            default:             is_dispatch_legal = 1'b0;
        endcase
    endfunction

    // True for the states that hold a memory handshake open.
    function automatic logic is_wait_state(input state_e st);
        case (st)
            S_FETCH_WAIT, S_ST_WAIT, S_LD_WAIT: is_wait_state = 1'b1;
            default:                            is_wait_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_output_rom.sv
// Combinational state -> control-word decode for the sequencer.
import cpu_ctrl_pkg::*;

module ctrl_output_rom (
    input  state_e     st,
    output ctrl_word_t word
);

    // Decode one state into its datapath strobes; unlisted states are idle.
    always_comb begin
        word        = '0;
        word.alu_op = ALU_ADD;
        case (st)
            S_FETCH_ADDR, S_ST_ADDR, S_LD_ADDR: word.mar_ld = 1'b1;
            S_FETCH_WAIT, S_LD_WAIT: begin
                word.mem_en = 1'b1;
                word.mem_rw = MEM_READ;
            end
            S_ST_WAIT: begin
                word.mem_en = 1'b1;
                word.mem_rw = MEM_WRITE;
            end
            S_IR_LOAD: begin
                word.ir_ld = 1'b1;
                word.pc_ld = 1'b1;
            end
            S_ST_DATA: word.mdr_ld = 1'b1;
            S_LD_WB: begin
                word.rf_ld  = 1'b1;
                word.rf_src = 1'b1;
            end
            S_BEQ:   word.alu_op = ALU_SUB;
            S_BR_TAKE: begin
                word.pc_ld  = 1'b1;
                word.pc_sel = 1'b1;
            end
            S_ADDU, S_ADDIU: word.rf_ld = 1'b1;
            S_SUBU: begin
                word.rf_ld  = 1'b1;
                word.alu_op = ALU_SUB;
            end
            S_SLTU, S_SLTIU: begin
                word.rf_ld  = 1'b1;
                word.alu_op = ALU_SLTU;
            end
            S_CLO: begin
                word.rf_ld  = 1'b1;
                word.alu_op = ALU_CLO;
            end
            S_CLZ: begin
                word.rf_ld  = 1'b1;
                word.alu_op = ALU_CLZ;
            end
            S_AND: begin
                word.rf_ld  = 1'b1;
                word.alu_op = ALU_AND;
            end
            S_ERROR: word.mem_err = 1'b1;
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle MIPS control FSM: fetch / decode / execute with bounded
// memory waits. Control outputs are registered from the next state, so they
// line up with the state register; only mdr_ld in LD_WAIT and the illegal
// pulse in DECODE look at live inputs.
import cpu_ctrl_pkg::*;

module control_sequencer #(
    parameter int STATE_W     = 7,
    parameter int MOC_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state_sel,
    input  logic               moc,
    input  logic               cond,
    output logic [STATE_W-1:0] state,
    output logic               pc_ld,
    output logic               pc_sel,
    output logic               mar_ld,
    output logic               mdr_ld,
    output logic               ir_ld,
    output logic               rf_ld,
    output logic               rf_src,
    output logic               mem_en,
    output logic               mem_rw,
    output logic [3:0]         alu_op,
    output logic               illegal,
    output logic               mem_err
);

    // Last wait-counter value that is still allowed before trapping.
    localparam logic [15:0] WAIT_LIMIT = 16'(MOC_TIMEOUT - 1);

    state_e                  state_r;
    state_e                  next_s;
    logic [15:0]             wait_cnt_r;
    ctrl_word_t              ctrl_r;
    ctrl_word_t              rom_s;
    logic [STATE_BITS-1:0]   sel_s;
    logic                    sel_legal_s;
    logic                    timeout_s;

    assign sel_s       = STATE_BITS'(state_sel);
    assign sel_legal_s = is_dispatch_legal(sel_s);
    assign timeout_s   = (wait_cnt_r == WAIT_LIMIT);

    // Next-state selection; a completed handshake beats a same-cycle timeout.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_RESET:      next_s = S_FETCH_ADDR;
            S_FETCH_ADDR: next_s = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (moc)            next_s = S_IR_LOAD;
                else if (timeout_s) next_s = S_ERROR;
                else                next_s = S_FETCH_WAIT;
            end
            S_IR_LOAD:    next_s = S_DECODE;
            S_DECODE: begin
                if (sel_legal_s) next_s = state_e'(sel_s);
                else             next_s = S_FETCH_ADDR;
            end
            S_ST_ADDR:    next_s = S_ST_DATA;
            S_ST_DATA:    next_s = S_ST_WAIT;
            S_ST_WAIT: begin
                if (moc)            next_s = S_FETCH_ADDR;
                else if (timeout_s) next_s = S_ERROR;
                else                next_s = S_ST_WAIT;
            end
            S_LD_ADDR:    next_s = S_LD_WAIT;
            S_LD_WAIT: begin
                if (moc)            next_s = S_LD_WB;
                else if (timeout_s) next_s = S_ERROR;
                else                next_s = S_LD_WAIT;
            end
            S_LD_WB:      next_s = S_FETCH_ADDR;
            S_BEQ: begin
                if (cond) next_s = S_BR_TAKE;
                else      next_s = S_FETCH_ADDR;
            end
            S_BR_TAKE:    next_s = S_FETCH_ADDR;
            S_ADDU, S_SUBU, S_ADDIU, S_SLTU,
            S_SLTIU, S_CLO, S_CLZ, S_AND: next_s = S_FETCH_ADDR;
            S_ERROR:      next_s = S_ERROR;
            default:      next_s = S_RESET;
        endcase
    end

    ctrl_output_rom u_rom (
        .st   (next_s),
        .word (rom_s)
    );

    // State register and registered control word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_RESET;
            ctrl_r  <= '0;
        end else begin
            state_r <= next_s;
            ctrl_r  <= rom_s;
        end
    end

    // Wait counter: restarts on entry to a wait state, counts idle moc cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 16'd0;
        end else if (is_wait_state(next_s) && !is_wait_state(state_r)) begin
            wait_cnt_r <= 16'd0;
        end else if (is_wait_state(state_r) && !moc) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign state   = STATE_W'(state_r);
    assign pc_ld   = ctrl_r.pc_ld;
    assign pc_sel  = ctrl_r.pc_sel;
    assign mar_ld  = ctrl_r.mar_ld;
    assign mdr_ld  = ctrl_r.mdr_ld | ((state_r == S_LD_WAIT) & moc);
    assign ir_ld   = ctrl_r.ir_ld;
    assign rf_ld   = ctrl_r.rf_ld;
    assign rf_src  = ctrl_r.rf_src;
    assign mem_en  = ctrl_r.mem_en;
    assign mem_rw  = ctrl_r.mem_rw;
    assign alu_op  = ctrl_r.alu_op;
    assign illegal = (state_r == S_DECODE) & ~sel_legal_s;
    assign mem_err = ctrl_r.mem_err;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a short moc timeout.
module tb_control_sequencer;

    localparam logic [15:0] PC_LD  = 16'h8000;
    localparam logic [15:0] PC_SEL = 16'h4000;
    localparam logic [15:0] MAR    = 16'h2000;
    localparam logic [15:0] MDR    = 16'h1000;
    localparam logic [15:0] IR     = 16'h0800;
    localparam logic [15:0] RF     = 16'h0400;
    localparam logic [15:0] RFSRC  = 16'h0200;
    localparam logic [15:0] MEN    = 16'h0100;
    localparam logic [15:0] MRW    = 16'h0080;
    localparam logic [15:0] ILL    = 16'h0004;
    localparam logic [15:0] MERR   = 16'h0002;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] state_sel;
    logic       moc;
    logic       cond;
    logic [6:0] state;
    logic       pc_ld, pc_sel, mar_ld, mdr_ld, ir_ld, rf_ld, rf_src;
    logic       mem_en, mem_rw, illegal, mem_err;
    logic [3:0] alu_op;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    control_sequencer #(.STATE_W(7), .MOC_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .state_sel(state_sel), .moc(moc), .cond(cond),
        .state(state), .pc_ld(pc_ld), .pc_sel(pc_sel), .mar_ld(mar_ld),
        .mdr_ld(mdr_ld), .ir_ld(ir_ld), .rf_ld(rf_ld), .rf_src(rf_src),
        .mem_en(mem_en), .mem_rw(mem_rw), .alu_op(alu_op),
        .illegal(illegal), .mem_err(mem_err)
    );

    function automatic logic [15:0] alu(input int op);
        return 16'(op << 3);
    endfunction

    function automatic logic [15:0] out_word();
        return {pc_ld, pc_sel, mar_ld, mdr_ld, ir_ld, rf_ld, rf_src,
                mem_en, mem_rw, alu_op, illegal, mem_err, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and check the state number and output word.
    task automatic cyc(input string tag, input int exp_state, input logic [15:0] exp_word);
        @(posedge clk);
        #1;
        check({tag, ".state"}, 32'(state), 32'(exp_state));
        check({tag, ".outs"}, 32'(out_word()), 32'(exp_word));
    endtask

    // Fetch sequence from an observed S1 with moc answering at once.
    task automatic fetch(input string tag, input logic [15:0] decode_word);
        moc = 1'b1;
        cyc({tag, ".s2"}, 2, MEN | MRW);
        cyc({tag, ".s3"}, 3, IR | PC_LD);
        cyc({tag, ".s4"}, 4, decode_word);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; moc = 1'b0; cond = 1'b0; state_sel = 7'd0;
        cyc("rst0", 0, 16'h0000);
        cyc("rst1", 0, 16'h0000);
        reset = 1'b0;
        cyc("s1_after_rst", 1, MAR);
        cyc("s2_wait", 2, MEN | MRW);
        cyc("s2_hold", 2, MEN | MRW);
        reset = 1'b1;
        cyc("rst_mid0", 0, 16'h0000);
        cyc("rst_mid1", 0, 16'h0000);
        reset = 1'b0;
        cyc("rst_mid_s1", 1, MAR);

        // ALU group
        state_sel = 7'd6;
        fetch("addu", 16'h0000);
        cyc("addu.ex", 6, RF | alu(0));
        cyc("addu.s1", 1, MAR);
        state_sel = 7'd17;
        fetch("subu", 16'h0000);
        cyc("subu.ex", 17, RF | alu(1));
        cyc("subu.s1", 1, MAR);
        state_sel = 7'd22;
        fetch("clz", 16'h0000);
        cyc("clz.ex", 22, RF | alu(4));
        cyc("clz.s1", 1, MAR);

        // Load; moc arrives on the 4th wait cycle, exactly at the limit
        state_sel = 7'd13;
        fetch("ld", 16'h0000);
        cyc("ld.addr", 13, MAR);
        moc = 1'b0;
        cyc("ld.w1", 14, MEN | MRW);
        cyc("ld.w2", 14, MEN | MRW);
        cyc("ld.w3", 14, MEN | MRW);
        cyc("ld.w4", 14, MEN | MRW);
        moc = 1'b1;
        #1;
        check("ld.mdr_on_moc", 32'(out_word()), 32'(MEN | MRW | MDR));
        cyc("ld.wb", 15, RF | RFSRC);
        cyc("ld.s1", 1, MAR);

        // Store; moc on the limit cycle completes normally
        state_sel = 7'd7;
        fetch("st", 16'h0000);
        cyc("st.addr", 7, MAR);
        cyc("st.data", 8, MDR);
        moc = 1'b0;
        cyc("st.w1", 9, MEN);
        cyc("st.w2", 9, MEN);
        cyc("st.w3", 9, MEN);
        cyc("st.w4", 9, MEN);
        moc = 1'b1;
        cyc("st.s1", 1, MAR);

        // BEQ taken / not taken
        state_sel = 7'd11; cond = 1'b1;
        fetch("beq_t", 16'h0000);
        cyc("beq_t.cmp", 11, alu(1));
        cyc("beq_t.take", 12, PC_LD | PC_SEL);
        cyc("beq_t.s1", 1, MAR);
        cond = 1'b0;
        fetch("beq_n", 16'h0000);
        cyc("beq_n.cmp", 11, alu(1));
        cyc("beq_n.s1", 1, MAR);

        // Illegal dispatch values
        state_sel = 7'd0;
        fetch("ill0", ILL);
        cyc("ill0.s1", 1, MAR);
        state_sel = 7'd16;
        fetch("ill16", ILL);
        cyc("ill16.s1", 1, MAR);
        state_sel = 7'd5;
        fetch("ill5", ILL);
        cyc("ill5.s1", 1, MAR);

        // Store timeout traps to ERROR, sticky until reset
        state_sel = 7'd7;
        fetch("to", 16'h0000);
        cyc("to.addr", 7, MAR);
        cyc("to.data", 8, MDR);
        moc = 1'b0;
        cyc("to.w1", 9, MEN);
        cyc("to.w2", 9, MEN);
        cyc("to.w3", 9, MEN);
        cyc("to.w4", 9, MEN);
        cyc("to.err", 16, MERR);
        moc = 1'b1;
        cyc("to.err_hold", 16, MERR);
        cyc("to.err_hold2", 16, MERR);
        reset = 1'b1;
        cyc("to.rst", 0, 16'h0000);
        reset = 1'b0;
        cyc("to.s1", 1, MAR);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
